// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//            with memory handshakes, trapping and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int ALU_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic [2:0]       dmem_size,
    input  logic             br_cond,
    output logic [ALU_W-1:0] alu_control,
    output logic [2:0]       imm_sel,
    output logic             alu_src_a_pc,
    output logic             alu_src_b_imm,
    output logic [1:0]       wb_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             pc_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    input  logic             trap_clr,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_TRAP   = 3'd5;

    localparam logic [3:0] c_CLS_NONE  = 4'd0;
    localparam logic [3:0] c_CLS_R     = 4'd1;
    localparam logic [3:0] c_CLS_IALU  = 4'd2;
    localparam logic [3:0] c_CLS_LOAD  = 4'd3;
    localparam logic [3:0] c_CLS_STORE = 4'd4;
    localparam logic [3:0] c_CLS_BR    = 4'd5;
    localparam logic [3:0] c_CLS_JAL   = 4'd6;
    localparam logic [3:0] c_CLS_JALR  = 4'd7;
    localparam logic [3:0] c_CLS_LUI   = 4'd8;
    localparam logic [3:0] c_CLS_AUIPC = 4'd9;

    localparam int                  c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                  c_TMO_EN    = (TIMEOUT > 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [31:0]         r_ir;
    logic [c_WAIT_W-1:0] r_wait;
    logic [1:0]          r_cause;
    logic [1:0]          w_cause_set;
    logic [CNT_W-1:0]    r_retired;
    logic                w_retire;
    logic [3:0]          w_cls;
    logic                w_illegal;
    logic [3:0]          w_alu_code;
    logic                w_tmo_hit;

    wire [6:0] w_opcode = r_ir[6:0];
    wire [2:0] w_funct3 = r_ir[14:12];
    wire       w_rd_nz  = (r_ir[11:7] != 5'd0);

    always_comb begin
        w_cls = c_CLS_NONE;
        case (w_opcode)
            7'b0110011: w_cls = c_CLS_R;
            7'b0010011: w_cls = c_CLS_IALU;
            7'b0000011: w_cls = c_CLS_LOAD;
            7'b0100011: w_cls = c_CLS_STORE;
            7'b1100011: w_cls = c_CLS_BR;
            7'b1101111: w_cls = c_CLS_JAL;
            7'b1100111: w_cls = c_CLS_JALR;
            7'b0110111: w_cls = c_CLS_LUI;
            7'b0010111: w_cls = c_CLS_AUIPC;
            default:    w_cls = c_CLS_NONE;
        endcase
    end

    assign w_illegal = (w_cls == c_CLS_NONE) ||
                       ((w_cls == c_CLS_LOAD) && ((w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11))) ||
                       ((w_cls == c_CLS_STORE) && (w_funct3 > 3'b010));

    // Only R-type uses instr[30] for add/sub; both R and I use it for srl/sra.
    always_comb begin
        w_alu_code = 4'b0000;
        if ((w_cls == c_CLS_R) || (w_cls == c_CLS_IALU)) begin
            case (w_funct3)
                3'b000:  w_alu_code = ((w_cls == c_CLS_R) && r_ir[30]) ? 4'b0001 : 4'b0000;
                3'b001:  w_alu_code = 4'b0010;
                3'b010:  w_alu_code = 4'b0011;
                3'b011:  w_alu_code = 4'b0100;
                3'b100:  w_alu_code = 4'b0101;
                3'b101:  w_alu_code = r_ir[30] ? 4'b0111 : 4'b0110;
                3'b110:  w_alu_code = 4'b1000;
                default: w_alu_code = 4'b1001;
            endcase
        end
    end

    assign w_tmo_hit = c_TMO_EN && (r_wait == c_WAIT_LAST);

    always_comb begin
        w_next        = r_state;
        w_cause_set   = 2'd0;
        w_retire      = 1'b0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_size     = 3'd0;
        alu_control   = '0;
        imm_sel       = 3'd0;
        alu_src_a_pc  = 1'b0;
        alu_src_b_imm = 1'b0;
        wb_sel        = 2'd0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        reg_we        = 1'b0;
        pc_sel        = 1'b0;
        // Outputs are forced low while reset is held so requests drop at once.
        if (rst_n) begin
            case (r_state)
                c_ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we  = 1'b1;
                        w_next = c_ST_DECODE;
                    end else if (w_tmo_hit) begin
                        w_next      = c_ST_TRAP;
                        w_cause_set = 2'd2;
                    end
                end
                c_ST_DECODE: begin
                    if (w_illegal) begin
                        w_next      = c_ST_TRAP;
                        w_cause_set = 2'd1;
                    end else begin
                        w_next = c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    alu_control   = ALU_W'(w_alu_code);
                    alu_src_b_imm = (w_cls != c_CLS_R);
                    alu_src_a_pc  = (w_cls == c_CLS_BR) || (w_cls == c_CLS_JAL) ||
                                    (w_cls == c_CLS_AUIPC);
                    case (w_cls)
                        c_CLS_IALU, c_CLS_LOAD, c_CLS_JALR: imm_sel = 3'd1;
                        c_CLS_STORE:                        imm_sel = 3'd2;
                        c_CLS_BR:                           imm_sel = 3'd3;
                        c_CLS_LUI, c_CLS_AUIPC:             imm_sel = 3'd4;
                        c_CLS_JAL:                          imm_sel = 3'd5;
                        default:                            imm_sel = 3'd0;
                    endcase
                    if (w_cls == c_CLS_BR) begin
                        pc_we    = 1'b1;
                        pc_sel   = br_cond;
                        w_retire = 1'b1;
                        w_next   = c_ST_FETCH;
                    end else if ((w_cls == c_CLS_LOAD) || (w_cls == c_CLS_STORE)) begin
                        w_next = c_ST_MEM;
                    end else begin
                        w_next = c_ST_WB;
                    end
                end
                c_ST_MEM: begin
                    dmem_req  = 1'b1;
                    dmem_we   = (w_cls == c_CLS_STORE);
                    dmem_size = w_funct3;
                    if (dmem_ready) begin
                        if (w_cls == c_CLS_STORE) begin
                            pc_we    = 1'b1;
                            w_retire = 1'b1;
                            w_next   = c_ST_FETCH;
                        end else begin
                            w_next = c_ST_WB;
                        end
                    end else if (w_tmo_hit) begin
                        w_next      = c_ST_TRAP;
                        w_cause_set = 2'd3;
                    end
                end
                c_ST_WB: begin
                    reg_we   = w_rd_nz;
                    pc_we    = 1'b1;
                    w_retire = 1'b1;
                    w_next   = c_ST_FETCH;
                    if (w_cls == c_CLS_LOAD) begin
                        wb_sel = 2'd1;
                    end else if ((w_cls == c_CLS_JAL) || (w_cls == c_CLS_JALR)) begin
                        wb_sel = 2'd2;
                        pc_sel = 1'b1;
                    end
                end
                c_ST_TRAP: begin
                    if (trap_clr) begin
                        w_next = c_ST_FETCH;
                    end
                end
                default: w_next = c_ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_FETCH;
            r_ir      <= 32'd0;
            r_wait    <= '0;
            r_cause   <= 2'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_ST_FETCH) && imem_ready) begin
                r_ir <= instr;
            end
            // Any state change restarts the wait count for the next FETCH/MEM.
            if (r_state != w_next) begin
                r_wait <= '0;
            end else if (((r_state == c_ST_FETCH) && !imem_ready) ||
                         ((r_state == c_ST_MEM) && !dmem_ready)) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_cause_set != 2'd0) begin
                r_cause <= w_cause_set;
            end else if ((r_state == c_ST_TRAP) && trap_clr) begin
                r_cause <= 2'd0;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign trap       = rst_n && (r_state == c_ST_TRAP);
    assign trap_cause = r_cause;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I decoder/controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using ready/req handshakes to instruction and data memory.
- Generates ALU, immediate, writeback and PC/register write strobes for RV32I R/I/load/store/branch/JAL/JALR/LUI/AUIPC.
- Adds illegal-instruction and memory-timeout trapping, plus a retired-instruction counter.

Parameters:
- ALU_W, 4, ALU_control width; codes occupy the low 4 bits, upper bits are 0.
- TIMEOUT, 16, maximum wait cycles for imem_ready/dmem_ready before trap; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction word, valid with imem_ready.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch complete; latch instr.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_ready  in  1  data access complete.
- dmem_size  out  3  funct3 of the load/store.
- br_cond  in  1  comparator result for the current branch (evaluated by the datapath per funct3).
- alu_control  out  ALU_W  ALU operation code.
- imm_sel  out  3  immediate type: 0 = none, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J.
- alu_src_a_pc  out  1  ALU operand A = PC.
- alu_src_b_imm  out  1  ALU operand B = immediate.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- ir_we, pc_we, reg_we  out  1  one-cycle write strobes.
- pc_sel  out  1  0 = PC+4, 1 = ALU result (branch/jump target).
- trap  out  1  sticky trap flag.
- trap_cause  out  2  1 = illegal instruction, 2 = imem timeout, 3 = dmem timeout.
- trap_clr  in  1  clears the trap and restarts at FETCH.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- **Reset (async, rst_n low):**
  - State goes to FETCH.
  - All strobes, req outputs, trap, trap_cause, retired, the wait counter and all other outputs are 0.
  - Asserting reset mid-access drops the requests immediately.
- **FETCH:**
  - imem_req = 1 and is held until imem_ready.
  - On imem_ready: ir_we pulses for 1 cycle, then go to DECODE.
- **DECODE (1 cycle):**
  - Classify the opcode: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode, or a load funct3 of 011/110/111, or a store funct3 > 010, sends the block to TRAP with cause 1.
- **EXEC (1 cycle):** drive alu_control, imm_sel and the operand selects.
  - ALU codes:
    - 0000 add / addi / address calc / AUIPC / JAL / JALR target.
    - 0001 sub.
    - 0010 sll/slli.
    - 0011 slt/slti.
    - 0100 sltu/sltiu.
    - 0101 xor/xori.
    - 0110 srl/srli.
    - 0111 sra/srai.
    - 1000 or/ori.
    - 1001 and/andi.
  - instr[30] distinguishes sub and sra/srai only; addi ignores instr[30].
  - LUI: operand A is forced to zero by the datapath; code 0000, imm_sel = U.
  - Branch: alu_src_a_pc = 1, imm_sel = B. If br_cond = 1, pc_sel = 1 and pc_we pulses; otherwise pc_sel = 0 and pc_we pulses. Instruction retires, next state FETCH.
  - Load/store: next state MEM.
  - All other classes: next state WB.
- **MEM:**
  - dmem_req = 1, dmem_we = (store), dmem_size = funct3; all held stable until dmem_ready.
  - Load: on dmem_ready go to WB.
  - Store: on dmem_ready, pc_we pulses (pc_sel = 0), instruction retires, next state FETCH.
- **WB (1 cycle):**
  - reg_we = 1, unless rd = 0, in which case reg_we = 0 (the instruction still retires).
  - wb_sel: 1 for loads, 2 for JAL/JALR, otherwise 0.
  - pc_we = 1. pc_sel = 1 for JAL/JALR, otherwise 0.
  - Next state FETCH.
- **Retirement:**
  - retired increments by 1 on every retiring cycle and wraps modulo 2^CNT_W.
  - Trapped instructions never retire.
- **Timeout:**
  - A wait counter resets to 0 on entering FETCH or MEM and increments each cycle ready is low.
  - If TIMEOUT > 0 and the counter reaches TIMEOUT with ready still low, go to TRAP with cause 2 (FETCH) or 3 (MEM).
  - A ready arriving in the same cycle the counter reaches TIMEOUT wins: no trap.
- **TRAP:**
  - trap = 1; all strobes and reqs = 0; cause is held.
  - On trap_clr: trap and trap_cause are cleared and the next state is FETCH.
  - trap_clr outside TRAP is ignored.
  - The PC is not modified by a trap.
- **Strobes:** all write strobes are single-cycle and mutually consistent; no strobe is asserted in FETCH except ir_we.

Test Plan:
- **add x3,x1,x2 (0x002081B3), imem_ready on the 1st cycle:**
  - ir_we at cycle 1, then DECODE, EXEC (alu_control = 0000), then WB with reg_we = 1, wb_sel = 0, pc_we = 1.
  - retired = 1 after 4 cycles.
- **lw x5,8(x1) (0x0080A283), dmem_ready delayed 3 cycles:**
  - dmem_req held 4 cycles with dmem_we = 0 and dmem_size = 010.
  - Then WB with wb_sel = 1 and reg_we = 1.
- **sra x1,x2,x3 (0x403150B3):** alu_control = 0111. **sub (0x40208033):** alu_control = 0001, and reg_we = 0 because rd = 0.
- **beq (0x00208463) with br_cond = 1, then with br_cond = 0:**
  - br_cond = 1: pc_sel = 1 and pc_we = 1 in EXEC; no reg_we.
  - br_cond = 0: pc_sel = 0; retired increments in both cases.
- **Opcode 0x0000007F:** trap = 1, trap_cause = 1, retired unchanged; trap_clr returns the block to FETCH with imem_req = 1.
- **TIMEOUT = 4, imem_ready held low:** trap_cause = 2 after 4 wait cycles. Repeat with imem_ready arriving on the 4th cycle: no trap.
